// File: rtl/relu_requant_pkg.sv
// Shared numeric format and layer-state codes for the requantizer.
// Holds the default element width and shift, the vector geometry
// (32 channels x 12 elements), the layer codes and the cs -> mode map.
package relu_requant_pkg;

  // Numeric format
  localparam int RQ_DATA_LEN = 18;
  localparam int RQ_SHIFT    = 4;

  // Vector geometry
  localparam int N_CH   = 32;
  localparam int N_LANE = 12;
  localparam int N_ELEM = N_CH * N_LANE;

  // Layer state codes
  localparam logic [3:0] LAYER0 = 4'd0;
  localparam logic [3:0] LAYER1 = 4'd1;
  localparam logic [3:0] LAYER2 = 4'd2;
  localparam logic [3:0] LAYER3 = 4'd3;
  localparam logic [3:0] AFFINE = 4'd4;

  typedef enum logic {
    MODE_PASS,
    MODE_RELU_SHIFT
  } mode_e;

  // Conv layers get ReLU + shift; AFFINE and any unknown code pass through.
  function automatic mode_e mode_from_cs(input logic [3:0] cs);
    mode_e m;
    case (cs)
      LAYER0, LAYER1, LAYER2, LAYER3: m = MODE_RELU_SHIFT;
      AFFINE:                         m = MODE_PASS;
      default:                        m = MODE_PASS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/relu_requant_lane.sv
// One-element requantizer lane (purely combinational).
// Ports:
//   mode_i  processing mode (pass-through or ReLU + rounding shift)
//   x_i     signed input element
//   y_o     requantized element
module relu_requant_lane
  import relu_requant_pkg::*;
#(
  parameter int DATA_LEN = RQ_DATA_LEN,
  parameter int SHIFT    = RQ_SHIFT
) (
  input  mode_e               mode_i,
  input  logic [DATA_LEN-1:0] x_i,
  output logic [DATA_LEN-1:0] y_o
);

  logic [DATA_LEN-1:0] relu_y;

  generate
    if (SHIFT == 0) begin : g_noshift
      assign relu_y = x_i[DATA_LEN-1] ? '0 : x_i;
    end else begin : g_shift
      localparam logic [DATA_LEN:0] HALF = (DATA_LEN + 1)'(1) << (SHIFT - 1);
      logic [DATA_LEN:0] sum;
      // One guard bit so the rounding add cannot wrap; the operand is known
      // non-negative here, so a logical shift equals the arithmetic shift.
      assign sum    = {1'b0, x_i} + HALF;
      assign relu_y = x_i[DATA_LEN-1] ? '0 : DATA_LEN'(sum >> SHIFT);
    end
  endgenerate

  assign y_o = (mode_i == MODE_RELU_SHIFT) ? relu_y : x_i;

endmodule

// File: rtl/relu_requant.sv
// ReLU / requantization engine for a 32-channel x 12-element vector.
// A job captures d and the mode on start, then processes one channel per
// cycle through 12 lanes; results land in q one cycle later via a stage
// register, and done pulses once the last channel has been written.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   start, cs   job request and layer code (sampled only in IDLE)
//   d           input vector, element 12*ch+k at [(12*ch+k)*DATA_LEN +: DATA_LEN]
//   q           output vector, same layout
//   busy, done  job in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// PROC  | issuing channels 0..31 and draining the stage register into q
// FIN   | q complete, done asserted for one cycle
module relu_requant
  import relu_requant_pkg::*;
#(
  parameter int DATA_LEN = RQ_DATA_LEN,
  parameter int SHIFT    = RQ_SHIFT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [3:0]                 cs,
  input  logic [N_ELEM*DATA_LEN-1:0] d,
  output logic [N_ELEM*DATA_LEN-1:0] q,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_FIN
  } state_e;

  typedef logic [N_LANE-1:0][DATA_LEN-1:0]            chan_t;
  typedef logic [N_CH-1:0][N_LANE-1:0][DATA_LEN-1:0]  vec_t;

  state_e     state_q, state_d;
  logic [5:0] ch_q, ch_d;
  logic       stg_vld_q, stg_vld_d;
  logic [4:0] stg_ch_q;
  chan_t      stg_q;
  chan_t      lane_y;
  vec_t       buf_q;
  vec_t       q_q;
  mode_e      mode_q;
  logic       accept;
  logic       issue;

  assign accept = (state_q == S_IDLE) && start;
  // ch_q reaches 32 after the last channel is issued; bit 5 stops issuing.
  assign issue  = (state_q == S_PROC) && !ch_q[5];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PROC;
      S_PROC: if (stg_vld_q && (stg_ch_q == 5'd31)) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_PROC: busy = 1'b1;
      S_FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ch_d      = ch_q;
    stg_vld_d = issue;
    if (accept)     ch_d = '0;
    else if (issue) ch_d = ch_q + 6'd1;
  end

  // Channel counter, stage valid and output vector (reset to zero)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q      <= '0;
      stg_vld_q <= 1'b0;
      q_q       <= '0;
    end else begin
      ch_q      <= ch_d;
      stg_vld_q <= stg_vld_d;
      if (stg_vld_q) q_q[stg_ch_q] <= stg_q;
    end
  end

  // Job capture and stage register carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q  <= d;
      mode_q <= mode_from_cs(cs);
    end
    if (issue) begin
      stg_q    <= lane_y;
      stg_ch_q <= ch_q[4:0];
    end
  end

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    relu_requant_lane #(
      .DATA_LEN(DATA_LEN),
      .SHIFT   (SHIFT)
    ) u_lane (
      .mode_i(mode_q),
      .x_i   (buf_q[ch_q[4:0]][k]),
      .y_o   (lane_y[k])
    );
  end

  assign q = q_q;

endmodule

// File: tb/tb_relu_requant.sv
module tb_relu_requant;
  import relu_requant_pkg::*;

  localparam int DL = RQ_DATA_LEN;
  localparam int VW = N_ELEM * DL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    cs;
  logic [VW-1:0] d;
  logic [VW-1:0] q;
  logic          busy;
  logic          done;

  int n_pass  = 0;
  int n_total = 0;

  relu_requant #(.DATA_LEN(DL), .SHIFT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .cs   (cs),
    .d    (d),
    .q    (q),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cs;
    int         x;
    int         y;
    string      name;
  } vec_rec_t;

  vec_rec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] exp);
    int bad = -1;
    n_total++;
    for (int i = N_ELEM - 1; i >= 0; i--)
      if (q[i*DL +: DL] !== exp[i*DL +: DL]) bad = i;
    if (bad < 0) n_pass++;
    else $display("FAIL %s: element %0d got %0d expected %0d", name, bad,
                  $signed(q[bad*DL +: DL]), $signed(exp[bad*DL +: DL]));
  endtask

  function automatic logic [VW-1:0] fill(input int x);
    logic [DL-1:0] e = DL'(x);
    return {N_ELEM{e}};
  endfunction

  function automatic logic [DL-1:0] ref_relu(input logic [DL-1:0] x);
    if (x[DL-1]) return '0;
    return DL'((int'(x) + 8) / 16);
  endfunction

  // Drives one start and waits for done; lat = posedges from start (incl. its sampling edge).
  task automatic run_job(input logic [3:0] c, input logic [VW-1:0] dv, output int lat);
    d     = dv;
    cs    = c;
    start = 1'b1;
    lat   = -1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (n == 1) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int            lat;
    int            ndone;
    logic [VW-1:0] pat;
    logic [VW-1:0] expv;

    tbl[0]  = '{LAYER0, -5,      0,      "l0_neg5"};
    tbl[1]  = '{LAYER1, 40,      3,      "l1_40"};
    tbl[2]  = '{LAYER1, 8,       1,      "l1_8_half_up"};
    tbl[3]  = '{LAYER1, 7,       0,      "l1_7"};
    tbl[4]  = '{LAYER1, 131071,  8192,   "l1_max"};
    tbl[5]  = '{LAYER2, 0,       0,      "l2_zero"};
    tbl[6]  = '{LAYER3, -131072, 0,      "l3_min"};
    tbl[7]  = '{LAYER2, 24,      2,      "l2_24"};
    tbl[8]  = '{LAYER3, 23,      1,      "l3_23"};
    tbl[9]  = '{AFFINE, -300,    -300,   "affine_neg300"};
    tbl[10] = '{AFFINE, 131071,  131071, "affine_max"};
    tbl[11] = '{4'hF,   77,      77,     "cs_f_pass"};
    tbl[12] = '{4'h9,   -1,      -1,     "cs_9_pass"};

    rst_n = 1'b0;
    start = 1'b0;
    cs    = '0;
    d     = '0;
    tick();
    tick();
    check_vec("reset_q", '0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      run_job(tbl[i].cs, fill(tbl[i].x), lat);
      check({tbl[i].name, "_lat"}, lat, 34);
      check_vec({tbl[i].name, "_q"}, fill(tbl[i].y));
      tick();
      check({tbl[i].name, "_idle"}, longint'({busy, done}), 0);
    end

    // Distinct per-element values: pass-through bit-exact, then ReLU per element
    for (int i = 0; i < N_ELEM; i++) pat[i*DL +: DL] = DL'(i * 1237 - 200000);
    run_job(AFFINE, pat, lat);
    check("affine_var_lat", lat, 34);
    check_vec("affine_var_q", pat);
    tick();
    for (int i = 0; i < N_ELEM; i++) expv[i*DL +: DL] = ref_relu(pat[i*DL +: DL]);
    run_job(LAYER3, pat, lat);
    check("l3_var_lat", lat, 34);
    check_vec("l3_var_q", expv);
    tick();

    // Restarts and input changes during a job are ignored
    d     = fill(40);
    cs    = LAYER1;
    start = 1'b1;
    ndone = 0;
    lat   = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 1) begin
        start = 1'b0;
        d     = fill(8);
        cs    = AFFINE;
      end
      if (n == 5 || n == 20) start = 1'b1;
      if (n == 6 || n == 21) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
    check("busy_start_ndone", ndone, 1);
    check("busy_start_lat", lat, 34);
    check_vec("busy_start_q", fill(3));

    // Reset in the middle of PROC aborts the job
    run_job(AFFINE, fill(-7), lat);
    tick();
    d     = fill(100);
    cs    = LAYER1;
    start = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    check_vec("abort_q", '0);
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_job(LAYER1, fill(40), lat);
    check("after_abort_lat", lat, 34);
    check_vec("after_abort_q", fill(3));

    // start in FIN ignored, start in the following IDLE cycle accepted
    d     = fill(99);
    cs    = AFFINE;
    start = 1'b1;
    tick();
    check("fin_start_ignored", longint'(busy), 0);
    tick();
    start = 1'b0;
    check("idle_start_taken", longint'(busy), 1);
    lat = -1;
    for (int n = 2; n <= 100; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    check("idle_start_lat", lat, 34);
    check_vec("idle_start_q", fill(99));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
